ps2_move_decoder: RTL and testbench

Receives PS/2 keyboard frames and converts arrow-key and WASD scan codes into the 3-bit `move` code that the game controller samples in its key-read state. The block deserializes 11-bit device-to-host frames and checks start, parity and stop bits. It tracks E0 (extended) and F0 (break) prefixes and holds the move for as long as the key is held. It sits between the board PS/2 pins and the controller's key register.

---
 rtl/ps2_move_decoder_pkg.sv | 56 +++++
 rtl/ps2_move_decoder_rx_frame.sv | 112 +++++++++++
 rtl/ps2_move_decoder.sv | 65 ++++++
 tb/tb_ps2_move_decoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_move_decoder_pkg.sv
// Shared definitions for the PS/2 move decoder: move codes, scan codes, key map.
package ps2_move_decoder_pkg;

  // Move codes sampled by the game controller in its key-read state.
  typedef enum logic [2:0] {
    MOVE_NONE  = 3'd0,
    MOVE_LEFT  = 3'd1,
    MOVE_RIGHT = 3'd2,
    MOVE_UP    = 3'd3,
    MOVE_DOWN  = 3'd4
  } move_e;

  // Receive frame states.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Set-2 scan codes.
  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;

  // Arrow codes only count behind an E0 prefix; WASD only without it.
  function automatic move_e key_to_move(input logic [7:0] code, input logic ext,
                                        input logic wasd_en);
    key_to_move = MOVE_NONE;
    if (ext) begin
      case (code)
        SC_LEFT:  key_to_move = MOVE_LEFT;
        SC_RIGHT: key_to_move = MOVE_RIGHT;
        SC_UP:    key_to_move = MOVE_UP;
        SC_DOWN:  key_to_move = MOVE_DOWN;
        default:  key_to_move = MOVE_NONE;
      endcase
    end else if (wasd_en) begin
      case (code)
        SC_A:    key_to_move = MOVE_LEFT;
        SC_D:    key_to_move = MOVE_RIGHT;
        SC_W:    key_to_move = MOVE_UP;
        SC_S:    key_to_move = MOVE_DOWN;
        default: key_to_move = MOVE_NONE;
      endcase
    end
  endfunction

endpackage

// File: rtl/ps2_move_decoder_rx_frame.sv
// PS/2 device-to-host frame receiver: pin synchronizers, 11-bit frame FSM
// with start/parity/stop checking, and an inactivity timeout.
module ps2_rx_frame
  import ps2_move_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  // Same-cycle strobes so the decoder can update on the same edge as byte_valid.
  output logic       good_stb,
  output logic       err_stb,
  output logic [7:0] shift_q
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1, clk_s2, clk_s3;
  logic          dat_s1, dat_s2;
  logic          fall, timeout;
  rx_state_e     state_q, state_d;
  logic [2:0]    bit_cnt_q;
  logic          par_q;
  logic [TW-1:0] tcnt_q;

  // Two-flop synchronizers, plus one extra clock stage for edge detection.
  // Reset to the idle-high level so no phantom edge appears after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall    = clk_s3 & ~clk_s2;
  assign timeout = (state_q != RX_IDLE) && !fall && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Frame state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RX_IDLE;
    else       state_q <= state_d;
  end

  // Next state and completion strobes; a falling edge always wins over timeout.
  always_comb begin
    state_d  = state_q;
    good_stb = 1'b0;
    err_stb  = 1'b0;
    if (fall) begin
      case (state_q)
        RX_IDLE:   if (!dat_s2) state_d = RX_DATA;
        RX_DATA:   if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        RX_PARITY: state_d = RX_STOP;
        RX_STOP: begin
          // Odd parity over data+parity, stop bit high.
          good_stb = dat_s2 && (^{shift_q, par_q});
          err_stb  = !good_stb;
          state_d  = RX_IDLE;
        end
        default:   state_d = RX_IDLE;
      endcase
    end else if (timeout) begin
      err_stb = 1'b1;
      state_d = RX_IDLE;
    end
  end

  // Data path: shift register, bit counter, parity capture, timeout counter, outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      tcnt_q     <= '0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      if (fall) begin
        case (state_q)
          RX_IDLE:   bit_cnt_q <= 3'd0;
          RX_DATA: begin
            shift_q[bit_cnt_q] <= dat_s2;
            bit_cnt_q          <= bit_cnt_q + 3'd1;
          end
          RX_PARITY: par_q <= dat_s2;
          default:   ;
        endcase
      end
      if (state_q == RX_IDLE || fall || timeout) tcnt_q <= '0;
      else                                       tcnt_q <= tcnt_q + TW'(1);
      byte_valid <= good_stb;
      frame_err  <= err_stb;
      if (good_stb) byte_data <= shift_q;
    end
  end

endmodule

// File: rtl/ps2_move_decoder.sv
// PS/2 arrow/WASD decoder: tracks E0/F0 prefixes on good bytes and holds the
// move code of the currently pressed direction key.
module ps2_move_decoder
  import ps2_move_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit WASD_EN        = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [2:0] move,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  logic       good_stb, err_stb;
  logic [7:0] rx_byte;
  logic       ext_q, brk_q;
  move_e      move_q, key;

  ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err),
    .good_stb  (good_stb),
    .err_stb   (err_stb),
    .shift_q   (rx_byte)
  );

  assign key  = key_to_move(rx_byte, ext_q, WASD_EN);
  assign move = move_q;

  // Prefix flags and held move; a break only releases the key currently held.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      move_q <= MOVE_NONE;
    end else if (err_stb) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (good_stb) begin
      if (rx_byte == SC_E0) begin
        ext_q <= 1'b1;
      end else if (rx_byte == SC_F0) begin
        brk_q <= 1'b1;
      end else begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
        if (key != MOVE_NONE) begin
          if (!brk_q)             move_q <= key;
          else if (move_q == key) move_q <= MOVE_NONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Randomized + directed bench for ps2_move_decoder; two instances share the
// PS/2 pins, one with WASD decoding enabled and one without.
module tb_ps2_move_decoder;

  localparam int T = 100;   // timeout cycles used in the bench
  localparam int H = 8;     // PS/2 clock half-period in clk cycles

  logic       clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [2:0] move1, move0;
  logic       bv1, bv0, fe1, fe0;
  logic [7:0] bd1, bd0;

  ps2_move_decoder #(.TIMEOUT_CYCLES(T), .WASD_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .move(move1), .byte_valid(bv1), .byte_data(bd1), .frame_err(fe1));

  ps2_move_decoder #(.TIMEOUT_CYCLES(T), .WASD_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .move(move0), .byte_valid(bv0), .byte_data(bd0), .frame_err(fe0));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit err; logic [7:0] data; int lo; int hi; } ev_t;
  ev_t q[$];

  int checks = 0, errors = 0;

  // Reference model state.
  bit         m_ext, m_brk;
  logic [2:0] m_move [2];   // [1]: WASD enabled, [0]: WASD disabled
  logic [2:0] ext_map  [bit [7:0]];
  logic [2:0] wasd_map [bit [7:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] lookup(input logic [7:0] b, input bit ext, input bit wasd);
    if (ext && ext_map.exists(b))          return ext_map[b];
    if (!ext && wasd && wasd_map.exists(b)) return wasd_map[b];
    return 3'd0;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [2:0] code;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      for (int i = 0; i < 2; i++) begin
        code = lookup(b, m_ext, i == 1);
        if (code != 0) begin
          if (!m_brk) m_move[i] = code;
          else if (m_move[i] == code) m_move[i] = 3'd0;
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic model_apply(input ev_t e);
    if (e.err) begin m_ext = 0; m_brk = 0; end
    else model_byte(e.data);
  endtask

  // Compare process: every cycle, match pulses against expected events and check move.
  always @(negedge clk) begin
    if (reset) begin
      m_ext = 0; m_brk = 0; m_move[0] = 0; m_move[1] = 0;
      q.delete();
    end else begin
      if (bv1 || fe1) begin
        if (q.size() == 0 || q[0].err != fe1 || bv1 == fe1) begin
          chk("unexpected_pulse", {30'd0, bv1, fe1}, 32'd0);
        end else begin
          checks++;
          if (cyc < q[0].lo || cyc > q[0].hi) begin
            errors++;
            $display("FAIL pulse_time actual=%0d required=%0d..%0d", cyc, q[0].lo, q[0].hi);
          end
          if (bv1) chk("byte_data", bd1, q[0].data);
          model_apply(q[0]);
          void'(q.pop_front());
        end
      end else if (q.size() > 0 && cyc > q[0].hi) begin
        checks++; errors++;
        $display("FAIL missing_pulse actual=none required=%s by cycle %0d",
                 q[0].err ? "frame_err" : "byte_valid", q[0].hi);
        model_apply(q[0]);
        void'(q.pop_front());
      end
      chk("move_wasd1", move1, m_move[1]);
      chk("move_wasd0", move0, m_move[0]);
    end
  end

  // Send one frame (or its first nbits bits); queue the expected event at the last falling edge.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input int nbits, input bit expect_ev);
    logic [10:0] bits;
    ev_t e;
    bits = {~bad_stop, ~(^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_data = bits[i];
      repeat (H/2) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == nbits - 1 && expect_ev) begin
        e.data = d;
        if (nbits == 11) begin
          e.err = bad_par | bad_stop; e.lo = cyc + 2; e.hi = cyc + 5;
        end else begin
          e.err = 1'b1; e.lo = cyc + T; e.hi = cyc + T + 6;
        end
        q.push_back(e);
      end
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (H/2) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic good(input logic [7:0] d);
    send_frame(d, 1'b0, 1'b0, 11, 1'b1);
  endtask

  task automatic settle();
    int n = 0;
    while (q.size() > 0 && n < 400) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_check(input string tag);
    @(posedge clk); #1;
    chk({tag, "_move1"}, move1, 0);
    chk({tag, "_move0"}, move0, 0);
    chk({tag, "_bv"}, bv1, 0);
    chk({tag, "_fe"}, fe1, 0);
    chk({tag, "_bd"}, bd1, 0);
  endtask

  logic [7:0] pool [11];

  initial begin
    ext_map[8'h6B] = 1; ext_map[8'h74] = 2; ext_map[8'h75] = 3; ext_map[8'h72] = 4;
    wasd_map[8'h1C] = 1; wasd_map[8'h23] = 2; wasd_map[8'h1D] = 3; wasd_map[8'h1B] = 4;
    pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h00};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset_check("reset");
    @(negedge clk) reset = 1'b0;
    repeat (5) @(negedge clk);

    // Arrow make.
    good(8'hE0); good(8'h6B); settle();
    chk("left_make", move1, 1);
    chk("left_make_bd", bd1, 8'h6B);
    chk("model_left", m_move[1], 1);
    // Break of the held key, then RIGHT.
    good(8'hE0); good(8'hF0); good(8'h6B); settle();
    chk("left_break", move1, 0);
    good(8'hE0); good(8'h74); settle();
    chk("right_make", move1, 2);
    // Break of a different key leaves UP held.
    good(8'hE0); good(8'h75); good(8'hE0); good(8'hF0); good(8'h72); settle();
    chk("other_break", move1, 3);
    chk("model_other_break", m_move[0], 3);
    // Release UP, then W.
    good(8'hE0); good(8'hF0); good(8'h75); good(8'h1D); settle();
    chk("wasd_on", move1, 3);
    chk("wasd_off", move0, 0);
    // Bad parity and bad stop: move held.
    send_frame(8'h6B, 1'b1, 1'b0, 11, 1'b1); settle();
    chk("bad_parity_move", move1, 3);
    send_frame(8'h6B, 1'b0, 1'b1, 11, 1'b1); settle();
    chk("bad_stop_move", move1, 3);
    // Truncated frame caught by timeout, then recovery.
    send_frame(8'h6B, 1'b0, 1'b0, 5, 1'b1); settle();
    good(8'hE0); good(8'h6B); settle();
    chk("after_timeout", move1, 1);
    // Reset in the middle of a frame.
    send_frame(8'h75, 1'b0, 1'b0, 5, 1'b0);
    @(negedge clk) reset = 1'b1;
    reset_check("midreset");
    @(negedge clk) reset = 1'b0;
    repeat (5) @(negedge clk);
    good(8'hE0); good(8'h75); settle();
    chk("after_reset_up", move1, 3);

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      logic [7:0] b;
      int r;
      b = pool[$urandom_range(0, 10)];
      if (b == 8'h00) b = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 99);
      send_frame(b, r < 8, r >= 8 && r < 12, 11, 1'b1);
    end
    settle();
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
